// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: frame-synchronous two-digit BCD to 7-segment scanner with registered outputs.
// Define DISP_LZB_EN to blank the tens digit when it is zero.
module bcd_7seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_unit,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       upd_pending
);
    localparam int W = $clog2(REFRESH_DIV);
    localparam logic [W-1:0] LAST = W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_OFF = ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic {TENS, UNITS} slot_t;

    slot_t        slot_q, slot_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [3:0]   tens_q, tens_d, unit_q, unit_d;
    logic [3:0]   ptens_q, ptens_d, punit_q, punit_d;
    logic         upd_q, upd_d;
    logic [6:0]   seg_q, seg_d, pat;
    logic [1:0]   dig_q, dig_d, en;
    logic [3:0]   cur;
    logic         tc, fb, blank;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7D;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h6F;
            default: dec = 7'h40;
        endcase
    endfunction

    // Outputs are decoded from next-state slot/display so a change is visible on the edge it happens.
    always_comb begin
        tc      = cnt_q == LAST;
        fb      = tc && slot_q == UNITS;
        cnt_d   = tc ? '0 : cnt_q + 1'b1;
        slot_d  = tc ? (slot_q == TENS ? UNITS : TENS) : slot_q;
        tens_d  = load && fb ? bcd_tens : fb && upd_q ? ptens_q : tens_q;
        unit_d  = load && fb ? bcd_unit : fb && upd_q ? punit_q : unit_q;
        ptens_d = load && !fb ? bcd_tens : ptens_q;
        punit_d = load && !fb ? bcd_unit : punit_q;
        upd_d   = load ? !fb : upd_q && !fb;
        cur     = slot_d == TENS ? tens_d : unit_d;
`ifdef DISP_LZB_EN
        blank   = slot_d == TENS && tens_d == 4'd0;
`else
        blank   = 1'b0;
`endif
        pat     = blank ? 7'h00 : dec(cur);
        en      = blank ? 2'b00 : slot_d == TENS ? 2'b10 : 2'b01;
        seg_d   = ACTIVE_LOW ? ~pat : pat;
        dig_d   = ACTIVE_LOW ? ~en : en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            slot_q  <= TENS;
            tens_q  <= '0;
            unit_q  <= '0;
            ptens_q <= '0;
            punit_q <= '0;
            upd_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            tens_q  <= tens_d;
            unit_q  <= unit_d;
            ptens_q <= ptens_d;
            punit_q <= punit_d;
            upd_q   <= upd_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg         = seg_q;
    assign dig_en      = dig_q;
    assign upd_pending = upd_q;
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// tb_bcd_7seg_scan: cycle-by-cycle vector table for the scanner at REFRESH_DIV=4, active-low.
module tb_bcd_7seg_scan;
`ifdef DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] ST0 = LZB ? 7'h7F : 7'h40;
    localparam logic [1:0] DT0 = LZB ? 2'b11 : 2'b01;

    typedef struct {
        logic       ld;
        logic [3:0] t;
        logic [3:0] u;
        logic [6:0] s;
        logic [1:0] d;
        logic       p;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b0, load = 1'b0;
    logic [3:0] bcd_tens = '0, bcd_unit = '0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       upd_pending;
    int         n_vec = 0, n_err = 0;
    vec_t       tbl[$];

    bcd_7seg_scan #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_tens(bcd_tens), .bcd_unit(bcd_unit),
        .seg(seg), .dig_en(dig_en), .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic ld, input logic [3:0] t, input logic [3:0] u,
                       input logic [6:0] s, input logic [1:0] d, input logic p);
        vec_t v;
        v.ld = ld; v.t = t; v.u = u; v.s = s; v.d = d; v.p = p;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic [6:0] s, input logic [1:0] d, input logic p);
        chk({nm, ".seg"}, {1'b0, seg}, {1'b0, s});
        chk({nm, ".dig_en"}, {6'b0, dig_en}, {6'b0, d});
        chk({nm, ".upd"}, {7'b0, upd_pending}, {7'b0, p});
    endtask

    task automatic step(input logic ld, input logic [3:0] t, input logic [3:0] u);
        load = ld; bcd_tens = t; bcd_unit = u;
        @(posedge clk);
        #1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        // edges 1..44 after reset release; frame boundaries fall on edges 8,16,24,32,40
        add(1, 0, 0, 0, ST0, DT0, 0);
        add(1, 1, 1, 5, ST0, DT0, 1);
        add(1, 0, 0, 0, ST0, DT0, 1);
        add(4, 0, 0, 0, 7'h40, 2'b10, 1);
        add(4, 0, 0, 0, 7'h79, 2'b01, 0);
        add(1, 0, 0, 0, 7'h12, 2'b10, 0);
        add(1, 1, 3, 4, 7'h12, 2'b10, 1);
        add(1, 1, 7, 8, 7'h12, 2'b10, 1);
        add(1, 0, 0, 0, 7'h12, 2'b10, 1);
        add(4, 0, 0, 0, 7'h78, 2'b01, 0);
        add(4, 0, 0, 0, 7'h00, 2'b10, 0);
        add(1, 1, 2, 9, 7'h24, 2'b01, 0);
        add(3, 0, 0, 0, 7'h24, 2'b01, 0);
        add(1, 0, 0, 0, 7'h10, 2'b10, 0);
        add(1, 1, 4'hA, 4'hC, 7'h10, 2'b10, 1);
        add(2, 0, 0, 0, 7'h10, 2'b10, 1);
        add(4, 0, 0, 0, 7'h3F, 2'b01, 0);
        add(2, 0, 0, 0, 7'h3F, 2'b10, 0);
        add(1, 1, 0, 3, 7'h3F, 2'b10, 1);
        add(1, 0, 0, 0, 7'h3F, 2'b10, 1);
        add(4, 0, 0, 0, ST0, DT0, 0);
        add(1, 0, 0, 0, 7'h30, 2'b10, 0);

        #2 rst = 1'b1;
        #1 chk_out("async_rst", 7'h7F, 2'b11, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("rst_held", 7'h7F, 2'b11, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            load = tbl[i].ld; bcd_tens = tbl[i].t; bcd_unit = tbl[i].u;
            @(posedge clk);
            #1;
            chk_out($sformatf("edge%0d", i + 1), tbl[i].s, tbl[i].d, tbl[i].p);
            @(negedge clk);
            load = 1'b0;
        end

        step(1, 5, 5);
        chk_out("mid_load", 7'h30, 2'b10, 1);
        step(0, 0, 0);
        rst = 1'b1;
        #1 chk_out("mid_rst", 7'h7F, 2'b11, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        chk_out("post_rst_e1", ST0, DT0, 0);
        repeat (3) step(0, 0, 0);
        chk_out("post_rst_e4", 7'h40, 2'b10, 0);
        repeat (4) step(0, 0, 0);
        chk_out("post_rst_e8", ST0, DT0, 0);
        repeat (4) step(0, 0, 0);
        chk_out("post_rst_e12", 7'h40, 2'b10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
- Downstream display stage for the binary-to-BCD converter.
- Accepts a tens/units BCD pair on a load strobe and holds it in a pending buffer.
- Commits the pair to the display only at a frame boundary, so a frame never shows mixed old/new digits.
- Time-multiplexes the two digits onto a 2-digit 7-segment display with a refresh prescaler; outputs are registered.

Parameters:
REFRESH_DIV, 50000, clocks per digit slot (≥2); frame = 2*REFRESH_DIV clocks
ACTIVE_LOW, 1, 1: seg and dig_en active-low (inactive = all ones); 0: active-high

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  one-cycle strobe; samples bcd_tens/bcd_unit
bcd_tens  input  4  tens BCD digit
bcd_unit  input  4  units BCD digit
seg  output  7  segments {g,f,e,d,c,b,a}; seg[0]=a
dig_en  output  2  digit enables; [1]=tens, [0]=units
upd_pending  output  1  high while a loaded pair awaits commit

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - prescaler = 0, slot = 0 (tens).
  - display regs = 0/0, pending regs = 0/0, upd_pending = 0.
  - seg = inactive (7'h7F if ACTIVE_LOW, else 7'h00).
  - dig_en = inactive (2'b11 if ACTIVE_LOW, else 2'b00).
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Terminal count (tc) = prescaler == REFRESH_DIV-1.
  - On tc the slot toggles: 0 = tens, 1 = units.
- Frame boundary (fb) = tc && slot==1.
- Scan state machine: two states, TENS and UNITS. Transition on tc only, TENS->UNITS->TENS.
- Load handling (per clock, in priority order):
  - load && fb: inputs go directly to display regs; pending unchanged; upd_pending <= 0.
  - load && !fb: inputs go to pending regs; upd_pending <= 1. Multiple loads before fb: last one wins.
  - !load && fb && upd_pending: pending -> display regs; upd_pending <= 0.
- Output register:
  - Each cycle, seg/dig_en are computed from the next slot and the next display regs, then registered.
  - Latency: outputs reflect a slot change or display commit on the same edge on which it occurs. The first edge after reset release drives tens=0.
  - Only the enable bit of the current slot is active; the other bit is inactive.
- Decode (active-high pattern; inverted when ACTIVE_LOW):
  - 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 = 7'h40 (dash; g only). This is not an error: no flag, no stall.
- No ghosting: seg and dig_en change on the same edge. No blanking interval is required.
- Reset mid-operation: returns immediately (asynchronously) to reset values. A pending update is discarded.
- Sizing: prescaler width is $clog2(REFRESH_DIV). Wrap must be exact for non-power-of-two divisors.

Optional Feature:
- Macro: DISP_LZB_EN (leading-zero blanking).
- Defined: when the display tens value == 0, the tens slot drives dig_en fully inactive and seg inactive. Slot timing is unchanged, so duty and brightness of the units digit are unaffected. Invalid tens (>9) is still shown as a dash.
- Undefined: tens 0 is shown as '0' (7'h3F pattern).

Test Plan (REFRESH_DIV=4, ACTIVE_LOW=1, frame = 8 clocks):
1. Reset held, then released -> seg=7'h7F, dig_en=2'b11, upd_pending=0 during reset; first edge after release gives dig_en=2'b01, seg=7'h40 ('0'; with DISP_LZB_EN: dig_en=2'b11, seg=7'h7F); units slot starts after 4 clocks with dig_en=2'b10.
2. load tens=1, unit=5 in cycle 1 of the tens slot -> upd_pending=1; current frame still shows 0/0; after fb, tens slot gives seg=7'h79 (~06), units slot gives seg=7'h12 (~6D); upd_pending=0.
3. load 3/4 then load 7/8 before the same fb -> only 7/8 is ever displayed (tens seg=7'h78, units seg=7'h00); 3/4 is never visible.
4. load tens=2, unit=9 exactly in the fb cycle -> upd_pending stays 0; the next tens slot shows seg=7'h24 (~5B).
5. load tens=4'hA, unit=4'hC -> both slots show seg=7'h3F (~40 dash); scan continues normally.
6. rst pulsed mid-units-slot with upd_pending=1 -> outputs go inactive immediately; upd_pending=0; after release, display shows 0/0.
